// File: rtl/calc_top.sv
// -----------------------------------------------------------------------------
// calc_top -- binary calculator top level
//
// An 8-bit ALU result is packed with its operands and flags into a 32-bit
// record {aluOp, flags, inA, inB, result}. Records are written into a 256x32
// memory. A read command loads a record into a shift register, and the record
// is sent LSB first as a serial stream. Each bit lasts N clk cycles, where N
// is the divider register value. Commands are accepted only in mode 1. Mode 1
// is selected by the serial key pattern 1,0,1,0 followed by a 1.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-high reset
//   inA, inB      in   operands (DATA_W)
//   aluOp         in   ALU operation select (4)
//   inputKey      in   serial key input, sampled every clk
//   RW            in   1 = compute + write, 0 = read + transmit
//   validCmd      in   command strobe (level)
//   ADDR          in   memory address (ADDR_W)
//   freqDivInput  in   serial bit period in clk cycles (32)
//   configDiv     in   load freqDivInput into the divider register
//   calcBusy      out  serial transfer in progress
//   DoutValid     out  DataOut carries a valid bit
//   DataOut       out  serial data, LSB first
//   clkTxOut      out  transmit clock, high for the first N/2 cycles of a bit
//
// Configuration
//   CALC_PARITY_EN  when defined, an even-parity bit of the record is sent
//                   after the MSB, so a transfer carries 33 bits.
// -----------------------------------------------------------------------------
module calc_top #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] inA,
    input  logic [DATA_W-1:0] inB,
    input  logic [3:0]        aluOp,
    input  logic              inputKey,
    input  logic              RW,
    input  logic              validCmd,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [31:0]       freqDivInput,
    input  logic              configDiv,
    output logic              calcBusy,
    output logic              DoutValid,
    output logic              DataOut,
    output logic              clkTxOut
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef CALC_PARITY_EN
    localparam int NBITS = WORD_W + 1;
`else
    localparam int NBITS = WORD_W;
`endif
    localparam logic [5:0] LAST_BIT = 6'(NBITS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } xfer_state_t;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [WORD_W-1:0] w);
        return ^w;
    endfunction

    // Storage and state
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [3:0]        hist_q, hist_d;
    logic              mode_q, mode_d;
    logic [31:0]       div_q, div_d;
    xfer_state_t       state_q, state_d;
    logic [31:0]       cyc_q, cyc_d;
    logic [5:0]        bit_q, bit_d;
    logic [NBITS-1:0]  shift_q, shift_d;
    logic              clk_tx_q, clk_tx_d;

    // ALU signals
    logic [DATA_W:0]     sum_s;
    logic [2*DATA_W-1:0] prod_s;
    logic [DATA_W-1:0]   res_s;
    logic                carry_s;
    logic                err_s;
    logic [3:0]          flags_s;
    logic [WORD_W-1:0]   word_s;
    logic                cmd_ok_s;
    logic                wr_en_s;
    logic                rd_en_s;

    // ALU: 8-bit result, carry is add carry-out / sub borrow / mul overflow
    always_comb begin
        sum_s   = '0;
        prod_s  = '0;
        res_s   = '0;
        carry_s = 1'b0;
        err_s   = 1'b0;
        case (aluOp)
            4'd0: begin
                sum_s   = {1'b0, inA} + {1'b0, inB};
                res_s   = sum_s[DATA_W-1:0];
                carry_s = sum_s[DATA_W];
            end
            4'd1: begin
                // Bit DATA_W of the widened difference is the borrow.
                sum_s   = {1'b0, inA} - {1'b0, inB};
                res_s   = sum_s[DATA_W-1:0];
                carry_s = sum_s[DATA_W];
            end
            4'd2: begin
                prod_s  = {{DATA_W{1'b0}}, inA} * {{DATA_W{1'b0}}, inB};
                res_s   = prod_s[DATA_W-1:0];
                carry_s = |prod_s[2*DATA_W-1:DATA_W];
            end
            4'd3: begin
                if (inB == '0) begin
                    err_s = 1'b1;
                end else begin
                    res_s = inA / inB;
                end
            end
            4'd4:    res_s = {inA[DATA_W-2:0], 1'b0};
            4'd5:    res_s = {1'b0, inA[DATA_W-1:1]};
            4'd6:    res_s = inA & inB;
            4'd7:    res_s = inA | inB;
            4'd8:    res_s = inA ^ inB;
            4'd9:    res_s = ~inA;
            default: err_s = 1'b1;
        endcase
        flags_s = {err_s, res_s[DATA_W-1], carry_s, (res_s == '0)};
        word_s  = {aluOp, flags_s, inA, inB, res_s};
    end

    // Command qualification: only mode 1 and only while the serial port is idle
    always_comb begin
        cmd_ok_s = mode_q && validCmd && (state_q == ST_IDLE);
        wr_en_s  = cmd_ok_s && RW;
        rd_en_s  = cmd_ok_s && !RW;
    end

    // Key history (oldest sample in bit 3); the pattern 1010 lets the current sample set the mode
    always_comb begin
        hist_d = {hist_q[2:0], inputKey};
        if (hist_q == 4'b1010) begin
            mode_d = inputKey;
        end else begin
            mode_d = mode_q;
        end
    end

    // Divider load and serial transfer sequencing
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        div_d   = div_q;
        case (state_q)
            ST_IDLE: begin
                // The divider only changes between transfers; N is kept >= 2.
                if (configDiv) begin
                    div_d = (freqDivInput < 32'd2) ? 32'd2 : freqDivInput;
                end else begin
                    div_d = div_q;
                end
                if (rd_en_s) begin
`ifdef CALC_PARITY_EN
                    shift_d = {even_parity(mem_q[ADDR]), mem_q[ADDR]};
`else
                    shift_d = mem_q[ADDR];
`endif
                    state_d = ST_XFER;
                    cyc_d   = 32'd0;
                    bit_d   = 6'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (cyc_q == div_q - 32'd1) begin
                    // Shifting in zeros leaves DataOut low once every bit is sent.
                    cyc_d   = 32'd0;
                    shift_d = {1'b0, shift_q[NBITS-1:1]};
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_IDLE;
                        bit_d   = 6'd0;
                    end else begin
                        bit_d   = bit_q + 6'd1;
                    end
                end else begin
                    cyc_d = cyc_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        clk_tx_d = (state_d == ST_XFER) && (cyc_d < {1'b0, div_d[31:1]});
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q   <= 4'b0000;
            mode_q   <= 1'b0;
            div_q    <= 32'd2;
            state_q  <= ST_IDLE;
            cyc_q    <= 32'd0;
            bit_q    <= 6'd0;
            shift_q  <= '0;
            clk_tx_q <= 1'b0;
        end else begin
            hist_q   <= hist_d;
            mode_q   <= mode_d;
            div_q    <= div_d;
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            clk_tx_q <= clk_tx_d;
        end
    end

    // Record memory, cleared on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_s) begin
            mem_q[ADDR] <= word_s;
        end
    end

    assign calcBusy  = (state_q == ST_XFER);
    assign DoutValid = (state_q == ST_XFER);
    assign DataOut   = shift_q[0];
    assign clkTxOut  = clk_tx_q;

endmodule

// File: tb/tb_calc_top.sv
module tb_calc_top;

`ifdef CALC_PARITY_EN
    localparam int NB = 33;
`else
    localparam int NB = 32;
`endif

    logic        clk;
    logic        reset;
    logic [7:0]  inA, inB, ADDR;
    logic [3:0]  aluOp;
    logic        inputKey, RW, validCmd, configDiv;
    logic [31:0] freqDivInput;
    logic        calcBusy, DoutValid, DataOut, clkTxOut;

    calc_top dut (
        .clk(clk), .reset(reset), .inA(inA), .inB(inB), .aluOp(aluOp),
        .inputKey(inputKey), .RW(RW), .validCmd(validCmd), .ADDR(ADDR),
        .freqDivInput(freqDivInput), .configDiv(configDiv),
        .calcBusy(calcBusy), .DoutValid(DoutValid), .DataOut(DataOut),
        .clkTxOut(clkTxOut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  addr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [15];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Key samples, first element first; key idles at 1 so idle samples never complete the pattern
    task automatic key_seq(input logic [4:0] bits);
        for (int i = 4; i >= 0; i--) begin
            inputKey = bits[i];
            tick();
        end
        inputKey = 1'b1;
    endtask

    task automatic outputs_idle(input string name);
        check(name, {28'd0, calcBusy, DoutValid, DataOut, clkTxOut}, 32'd0);
    endtask

    // One-cycle read command, then capture the serial word and the busy length
    task automatic do_read(input logic [7:0] addr, input int n, input logic cfg_during,
                           output logic [31:0] w, output int busy_len, output int txerr);
        validCmd = 1'b1;
        RW       = 1'b0;
        ADDR     = addr;
        tick();
        validCmd  = 1'b0;
        configDiv = cfg_during;
        busy_len  = 0;
        txerr     = 0;
        w         = 32'd0;
        while (calcBusy === 1'b1 && busy_len < 40 * n + 10) begin
            if ((busy_len % n) == 0 && (busy_len / n) < 32) w[busy_len / n] = DataOut;
            if (clkTxOut !== ((busy_len % n) < (n / 2))) txerr++;
            if (DoutValid !== 1'b1) txerr++;
            busy_len++;
            tick();
        end
        configDiv = 1'b0;
    endtask

    logic [31:0] w;
    int          blen, txerr, gap;

    initial begin
        vecs[0]  = '{4'd0,  8'd7,    8'd8,    8'd4,  32'h0007080F};
        vecs[1]  = '{4'd1,  8'd3,    8'd5,    8'd5,  32'h160305FE};
        vecs[2]  = '{4'd3,  8'd9,    8'd0,    8'd6,  32'h39090000};
        vecs[3]  = '{4'd0,  8'd200,  8'd100,  8'd7,  32'h02C8642C};
        vecs[4]  = '{4'd2,  8'd16,   8'd16,   8'd8,  32'h23101000};
        vecs[5]  = '{4'd3,  8'd100,  8'd7,    8'd10, 32'h3064070E};
        vecs[6]  = '{4'd4,  8'h81,   8'h00,   8'd11, 32'h40810002};
        vecs[7]  = '{4'd5,  8'h81,   8'h00,   8'd12, 32'h50810040};
        vecs[8]  = '{4'd6,  8'hF0,   8'h3C,   8'd13, 32'h60F03C30};
        vecs[9]  = '{4'd7,  8'hF0,   8'h0F,   8'd14, 32'h74F00FFF};
        vecs[10] = '{4'd8,  8'hAA,   8'hAA,   8'd15, 32'h81AAAA00};
        vecs[11] = '{4'd9,  8'h0F,   8'h55,   8'd16, 32'h940F55F0};
        vecs[12] = '{4'd12, 8'h05,   8'h06,   8'd17, 32'hC9050600};
        vecs[13] = '{4'd1,  8'h05,   8'h03,   8'd18, 32'h10050302};
        vecs[14] = '{4'd2,  8'd20,   8'd13,   8'd19, 32'h22140D04};

        reset = 1'b1; inA = 8'd0; inB = 8'd0; ADDR = 8'd0; aluOp = 4'd0;
        inputKey = 1'b0; RW = 1'b0; validCmd = 1'b0; configDiv = 1'b0;
        freqDivInput = 32'd0;
        #8;
        outputs_idle("reset_outputs");
        #5 reset = 1'b0;
        tick();
        outputs_idle("post_reset_outputs");

        // Unlock while a write to address 9 is requested; mode is still 0 on every key edge
        validCmd = 1'b1; RW = 1'b1; ADDR = 8'd9; aluOp = 4'd0; inA = 8'd1; inB = 8'd1;
        key_seq(5'b10101);
        validCmd = 1'b0;

        // Table writes, one record per cycle
        for (int i = 0; i < 15; i++) begin
            aluOp = vecs[i].op; inA = vecs[i].a; inB = vecs[i].b; ADDR = vecs[i].addr;
            validCmd = 1'b1; RW = 1'b1;
            tick();
        end
        validCmd = 1'b0;
        outputs_idle("outputs_after_writes");

        // N=4, divider write attempted during the transfer must be ignored
        freqDivInput = 32'd4; configDiv = 1'b1; tick(); configDiv = 1'b0;
        freqDivInput = 32'd8;
        do_read(8'd4, 4, 1'b1, w, blen, txerr);
        check("read4_n4_word", w, 32'h0007080F);
        check("read4_n4_busy_len", blen, NB * 4);
        check("read4_n4_clktx_errors", txerr, 0);
        outputs_idle("idle_after_read4");

        // Back to N=2 and read every table record
        freqDivInput = 32'd2; configDiv = 1'b1; tick(); configDiv = 1'b0;
        for (int i = 0; i < 15; i++) begin
            do_read(vecs[i].addr, 2, 1'b0, w, blen, txerr);
            check($sformatf("vec%0d_word", i), w, vecs[i].exp);
            check($sformatf("vec%0d_busy_len", i), blen, NB * 2);
            check($sformatf("vec%0d_tx_errors", i), txerr, 0);
        end

        // Address 9 was never written (mode 0 during the unlock)
        do_read(8'd9, 2, 1'b0, w, blen, txerr);
        check("addr9_untouched", w, 32'd0);

        // Held read command restarts after one idle cycle; a write during busy is dropped
        validCmd = 1'b1; RW = 1'b0; ADDR = 8'd5;
        tick();
        blen = 0;
        while (calcBusy === 1'b1 && blen < 200) begin blen++; tick(); end
        check("restart_first_len", blen, NB * 2);
        gap = 0;
        while (calcBusy !== 1'b1 && gap < 5) begin gap++; tick(); end
        check("restart_gap", gap, 1);
        RW = 1'b1; ADDR = 8'd30; aluOp = 4'd0; inA = 8'd1; inB = 8'd2;
        tick();
        validCmd = 1'b0;
        blen = 0;
        while (calcBusy === 1'b1 && blen < 200) begin blen++; tick(); end
        check("restart_second_done", calcBusy, 1'b0);
        do_read(8'd30, 2, 1'b0, w, blen, txerr);
        check("write_during_busy_dropped", w, 32'd0);

        // Lock with 1,0,1,0,0; mode-0 commands are ignored
        key_seq(5'b10100);
        validCmd = 1'b1; RW = 1'b1; ADDR = 8'd4; aluOp = 4'd6; inA = 8'hFF; inB = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            outputs_idle($sformatf("mode0_write_outputs%0d", i));
        end
        RW = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            outputs_idle($sformatf("mode0_read_outputs%0d", i));
        end
        validCmd = 1'b0;
        key_seq(5'b10101);
        do_read(8'd4, 2, 1'b0, w, blen, txerr);
        check("mode0_mem_unchanged", w, 32'h0007080F);

        // Reset mid-transfer clears outputs without a clock edge
        validCmd = 1'b1; RW = 1'b0; ADDR = 8'd4;
        tick();
        validCmd = 1'b0;
        repeat (10) tick();
        check("busy_before_reset", calcBusy, 1'b1);
        #2 reset = 1'b1;
        #1 outputs_idle("async_reset_outputs");
        #3 reset = 1'b0;
        tick();
        outputs_idle("after_reset_outputs");

        // freqDivInput of 1 and 0 are both stored as 2
        key_seq(5'b10101);
        freqDivInput = 32'd1; configDiv = 1'b1; tick(); configDiv = 1'b0;
        do_read(8'd4, 2, 1'b0, w, blen, txerr);
        check("div1_busy_len", blen, NB * 2);
        check("mem_cleared_by_reset", w, 32'd0);
        freqDivInput = 32'd0; configDiv = 1'b1; tick(); configDiv = 1'b0;
        do_read(8'd4, 2, 1'b0, w, blen, txerr);
        check("div0_busy_len", blen, NB * 2);
        check("div0_tx_errors", txerr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
